// File: rtl/ram_pkg.sv
// Shared definitions for the Wishbone RAM slave.
//   LATENCY_MAX : largest supported request-to-termination latency.
//   CNT_W       : width of the wait counter (holds 0..LATENCY_MAX-1).
//   state_e     : controller states.
package ram_pkg;

  localparam int unsigned LATENCY_MAX = 4;
  localparam int unsigned CNT_W       = $clog2(LATENCY_MAX);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/ram_array.sv
// Word-organised storage with a byte-enabled write port and a registered read port.
// Ports:
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset (clears the read register only, never memory)
//   i_we     : write enable; i_sel selects the bytes of i_wdata written to i_waddr
//   i_re     : read enable; o_rdata loads the word at i_raddr and holds it otherwise
module ram_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned NB    = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [NB-1:0]     i_sel,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (i_sel[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_wb.sv
// Wishbone classic slave in front of a single-port RAM with fixed access latency.
// A request (cyc_i & stb_i) taken in IDLE is terminated exactly LATENCY cycles later
// by a one-cycle ack_o (in range) or err_o (adr >= DEPTH). Dropping cyc_i while the
// transfer is outstanding aborts it silently.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-low reset
//   cyc_i, stb_i, we_i : bus cycle, strobe, write select
//   sel_i, adr_i, dat_i: byte enables, word address, write data
//   dat_o              : read data, updated only for a read that acks
//   ack_o, err_o       : normal / error termination
module ram_wb
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [ADDR_W-1:0]   adr_i,
  input  logic [DATA_W-1:0]   dat_i,
  output logic [DATA_W-1:0]   dat_o,
  output logic                ack_o,
  output logic                err_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NB    = DATA_W / 8;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ack;
  logic              r_err;
  logic              r_we;
  logic [NB-1:0]     r_sel;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;

  logic              w_req;
  logic              w_in_range_i;
  logic              w_in_range_q;
  logic              w_last_busy;
  logic              w_rd_en;
  logic [IDX_W-1:0]  w_rd_addr;
  logic              w_wr_en;

  assign w_req        = cyc_i & stb_i;
  assign w_in_range_i = ({1'b0, adr_i} < DEPTH_L);
  assign w_in_range_q = ({1'b0, r_adr} < DEPTH_L);
  assign w_last_busy  = (r_state == StBusy) && cyc_i && (r_cnt == CNT_W'(1));

  // The read is launched on the edge that enters DONE, so the registered array output
  // is valid exactly in the ack cycle. With LATENCY=1 that edge is the capture edge
  // itself, hence the live address from the bus.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = r_adr[IDX_W-1:0];
    if (r_state == StIdle) begin
      w_rd_addr = adr_i[IDX_W-1:0];
      w_rd_en   = (LATENCY == 1) && w_req && !we_i && w_in_range_i;
    end else if (w_last_busy) begin
      w_rd_en = !r_we && w_in_range_q;
    end
  end

  // Commit on the edge that ends the ack cycle, unless the master abandoned the cycle.
  assign w_wr_en = rst_i && (r_state == StDone) && r_ack && r_we && cyc_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_cnt <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              r_state <= StDone;
              r_ack   <= w_in_range_i;
              r_err   <= !w_in_range_i;
            end else begin
              r_state <= StBusy;
            end
          end
        end
        StBusy: begin
          if (!cyc_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= StDone;
              r_ack   <= w_in_range_q;
              r_err   <= !w_in_range_q;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Capture registers are only meaningful after a request, so they need no reset.
  always_ff @(posedge clk_i) begin
    if ((r_state == StIdle) && w_req) begin
      r_we  <= we_i;
      r_sel <= sel_i;
      r_adr <= adr_i;
      r_dat <= dat_i;
    end
  end

  ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram_array (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_we    (w_wr_en),
    .i_sel   (r_sel),
    .i_waddr (r_adr[IDX_W-1:0]),
    .i_wdata (r_dat),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (dat_o)
  );

  assign ack_o = r_ack;
  assign err_o = r_err;

endmodule
